elm_layer_sequencer: RTL and testbench
======================================

Name: elm_layer_sequencer

Overview:
Sequences one hidden layer of ELM neurons that share a broadcast weight, bias and input bus. It has two phases. First it loads bias and weights from a host config stream into each neuron in turn. It then streams each input vector to all neurons, waits until every neuron raises outvalid, and reports completion. It sits between the AXI front-end FIFOs and the array of neuron instances for one layer.

Parameters:
DATA_W, 16, width of weights, biases and input samples (matches `dataWidth).
NUM_NEURONS, 16, number of neurons in the layer.
NUM_WEIGHT, 128, weights per neuron, which is also the number of samples per input vector.
LAYER_NO, 1, value driven on config_layer_num.
TIMEOUT, 64, maximum number of cycles in WAIT_OUT before the error flag is set.

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-low
cfg_start  in  1  pulse; starts a full reload
cfg_data  in  DATA_W  bias/weight word from host
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  config word accepted when cfg_valid & cfg_ready
in_data  in  DATA_W  input sample
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid & in_ready
neuron_rst  out  1  active-high reset to neurons
weight_value  out  DATA_W  broadcast weight
weight_valid  out  1  weight strobe
bias_value  out  DATA_W  broadcast bias
bias_valid  out  NUM_NEURONS  one-hot per-neuron bias strobe
config_layer_num  out  2*DATA_W+1  constant LAYER_NO
config_neuron_num  out  2*DATA_W+1  target neuron index
neuron_in  out  DATA_W  broadcast input sample
neuron_in_valid  out  1  input strobe
neuron_outvalid  in  NUM_NEURONS  outvalid from each neuron
ready  out  1  layer loaded and idle
vec_done  out  1  1-cycle pulse when all neurons have produced an output
err_timeout  out  1  sticky; cleared by cfg_start

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE. All outputs are 0 except neuron_rst=1 and config_layer_num=LAYER_NO. Reset mid-operation aborts immediately, with no partial completion pulse.
- States: IDLE, NRST, LOAD_BIAS, LOAD_W, READY, STREAM, WAIT_OUT, DONE.
- IDLE: on cfg_start go to NRST.
- NRST: drive neuron_rst=1 for exactly 2 cycles. This resets each neuron's weight write address to all-ones, so the first write lands at address 0. Then clear neuron index n=0 and go to LOAD_BIAS.
- LOAD_BIAS: cfg_ready=1. On accept, register bias_value=cfg_data and pulse bias_valid[n] for 1 cycle. Clear weight count k and go to LOAD_W.
- LOAD_W: cfg_ready=1 and config_neuron_num=n. On each accept, register weight_value=cfg_data, pulse weight_valid for 1 cycle, and increment k.
  - When k reaches NUM_WEIGHT: if n==NUM_NEURONS-1, go to READY; otherwise increment n and go to LOAD_BIAS.
  - config_neuron_num is held stable for 1 cycle after the last weight_valid.
  - Gaps in cfg_valid are allowed.
- Config word order per neuron: 1 bias word, then NUM_WEIGHT weight words. Total words = NUM_NEURONS*(NUM_WEIGHT+1).
- READY: ready=1, in_ready=1. An accepted sample clears count j and moves to STREAM; that accepted sample counts as j=1. cfg_start in READY goes to NRST (full reload).
- STREAM: in_ready=1. Each accepted sample drives neuron_in/neuron_in_valid registered with 1 cycle latency. Gaps in in_valid are allowed. After the NUM_WEIGHT-th accept, in_ready drops the same cycle and the state goes to WAIT_OUT.
  - neuron_in_valid must be low for at least 1 cycle after the last sample. The neurons finalise on the falling edge of their input valid.
- WAIT_OUT: accumulate seen |= neuron_outvalid (sticky per neuron). When seen is all ones, go to DONE. If the cycle counter reaches TIMEOUT first, set err_timeout=1 and go to READY without vec_done.
- DONE: vec_done=1 for 1 cycle, clear seen, return to READY.
- Nominal latency from last sample accept to vec_done is 7 cycles: 1 cycle output register + 5 cycles neuron pipeline + 1 cycle DONE.
- cfg_start in any state other than IDLE or READY is ignored. cfg_valid outside load states is not accepted.
- Counter widths: n is $clog2(NUM_NEURONS), k and j are $clog2(NUM_WEIGHT)+1, and the timeout counter is $clog2(TIMEOUT)+1. No counter may wrap.

Decomposition:
- Shared package holds the state encoding (3-bit enum) and the config_num width constant 2*DATA_W+1.
- One natural sub-module, elm_seq_counter: a parameterised up-counter with clear, enable and terminal-count flag, instantiated for n, k, j and timeout.

Test Plan:
- Reset, then cfg_start with NUM_NEURONS=4, NUM_WEIGHT=8 and 36 config words -> neuron_rst high for 2 cycles; exactly 4 bias_valid pulses (one-hot 0001, 0010, 0100, 1000); 32 weight_valid pulses with config_neuron_num 0,0..(8x),1..,3; ready=1 after the last word.
- Config stream with cfg_valid toggling every other cycle -> same pulse counts, no dropped or duplicated word.
- 8 samples in back-to-back; model neurons assert outvalid 5 cycles after the neuron_in_valid falling edge -> in_ready low after the 8th accept; vec_done exactly 7 cycles after the last accept.
- Neurons assert outvalid in staggered cycles (neuron 2 three cycles late) -> vec_done only after neuron 2's outvalid; seen is cleared so the next vector completes independently.
- Neuron 3 never asserts outvalid, TIMEOUT=16 -> err_timeout=1 after 16 WAIT_OUT cycles, no vec_done, return to READY; err_timeout clears on the next cfg_start.
- rst=0 mid-LOAD_W at k=5 -> next cycle all strobes are 0 and the state is IDLE; a subsequent full cfg_start reload completes normally.

Source files
------------

// File: rtl/elm_layer_sequencer_pkg.sv
// elm_layer_sequencer_pkg: shared state encoding and
// width helpers for the ELM hidden-layer sequencer.
package elm_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NRST,
    S_LOAD_BIAS,
    S_LOAD_W,
    S_READY,
    S_STREAM,
    S_WAIT_OUT,
    S_DONE
  } seq_state_e;

  localparam int DATA_W_DEF = 16;

  function automatic int cfg_num_w(input int dw);
    return 2 * dw + 1;
  endfunction

  localparam int CFG_NUM_W = cfg_num_w(DATA_W_DEF);

endpackage

// File: rtl/elm_seq_counter.sv
// elm_seq_counter: saturating up-counter with clear,
// enable and terminal-count flag.
module elm_seq_counter #(
  parameter int W    = 4,
  parameter int TERM = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = cnt == W'(TERM);

  // clr with en loads 1 so the triggering event is counted
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= en ? W'(1) : '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/elm_layer_sequencer.sv
// elm_layer_sequencer: loads bias/weights into one ELM
// layer, then streams input vectors and waits for outvalid.
module elm_layer_sequencer
  import elm_layer_sequencer_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_NEURONS = 16,
  parameter int NUM_WEIGHT  = 128,
  parameter int LAYER_NO    = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [DATA_W-1:0]      cfg_data,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   neuron_rst,
  output logic [DATA_W-1:0]      weight_value,
  output logic                   weight_valid,
  output logic [DATA_W-1:0]      bias_value,
  output logic [NUM_NEURONS-1:0] bias_valid,
  output logic [2*DATA_W:0]      config_layer_num,
  output logic [2*DATA_W:0]      config_neuron_num,
  output logic [DATA_W-1:0]      neuron_in,
  output logic                   neuron_in_valid,
  input  logic [NUM_NEURONS-1:0] neuron_outvalid,
  output logic                   ready,
  output logic                   vec_done,
  output logic                   err_timeout
);

  localparam int NUM_W = cfg_num_w(DATA_W);
  localparam int NB =
    (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int KB = $clog2(NUM_WEIGHT) + 1;
  localparam int TB = $clog2(TIMEOUT) + 1;
  localparam logic [NUM_NEURONS-1:0] OH0 =
    NUM_NEURONS'(1);

  seq_state_e state;
  logic nrst_cnt;
  logic [NUM_NEURONS-1:0] seen;

  logic [NB-1:0] n;
  logic [KB-1:0] k;
  logic [KB-1:0] j;
  logic [TB-1:0] t;
  logic n_tc, k_tc, j_tc, t_tc;
  logic n_clr, n_en, k_clr, k_en;
  logic j_clr, j_en, t_clr, t_en;

  logic cfg_fire, in_fire;
  logic k_last, j_last, all_seen;
  logic unused_t;

  assign unused_t = ^t;

  assign cfg_ready =
    (state == S_LOAD_BIAS) ||
    (state == S_LOAD_W && !k_tc);
  // a reload request in READY wins over a sample
  assign in_ready =
    (state == S_READY && !cfg_start) ||
    (state == S_STREAM && !j_tc);
  assign ready = state == S_READY;

  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;

  assign k_last = k == KB'(NUM_WEIGHT - 1);
  assign j_last = (state == S_READY) ?
    (NUM_WEIGHT == 1) :
    (j == KB'(NUM_WEIGHT - 1));
  assign all_seen = &(seen | neuron_outvalid);

  assign config_layer_num = NUM_W'(LAYER_NO);

  assign n_clr = state == S_NRST;
  assign n_en  = state == S_LOAD_W && cfg_fire &&
                 k_last && !n_tc;
  assign k_clr = state == S_LOAD_BIAS && cfg_fire;
  assign k_en  = state == S_LOAD_W && cfg_fire;
  assign j_clr = state == S_READY && in_fire;
  assign j_en  = in_fire;
  assign t_clr = in_fire && j_last;
  assign t_en  = state == S_WAIT_OUT || t_clr;

  elm_seq_counter #(.W(NB), .TERM(NUM_NEURONS - 1))
  u_n_cnt (
    .clk (clk),
    .rst (rst),
    .clr (n_clr),
    .en  (n_en),
    .cnt (n),
    .tc  (n_tc)
  );

  elm_seq_counter #(.W(KB), .TERM(NUM_WEIGHT))
  u_k_cnt (
    .clk (clk),
    .rst (rst),
    .clr (k_clr),
    .en  (k_en),
    .cnt (k),
    .tc  (k_tc)
  );

  elm_seq_counter #(.W(KB), .TERM(NUM_WEIGHT))
  u_j_cnt (
    .clk (clk),
    .rst (rst),
    .clr (j_clr),
    .en  (j_en),
    .cnt (j),
    .tc  (j_tc)
  );

  elm_seq_counter #(.W(TB), .TERM(TIMEOUT))
  u_t_cnt (
    .clk (clk),
    .rst (rst),
    .clr (t_clr),
    .en  (t_en),
    .cnt (t),
    .tc  (t_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= S_IDLE;
      nrst_cnt          <= 1'b0;
      seen              <= '0;
      neuron_rst        <= 1'b1;
      weight_value      <= '0;
      weight_valid      <= 1'b0;
      bias_value        <= '0;
      bias_valid        <= '0;
      config_neuron_num <= '0;
      neuron_in         <= '0;
      neuron_in_valid   <= 1'b0;
      vec_done          <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      weight_valid    <= 1'b0;
      bias_valid      <= '0;
      neuron_in_valid <= 1'b0;
      vec_done        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          neuron_rst <= 1'b0;
          if (cfg_start) begin
            state       <= S_NRST;
            neuron_rst  <= 1'b1;
            nrst_cnt    <= 1'b0;
            err_timeout <= 1'b0;
          end
        end
        S_NRST: begin
          if (nrst_cnt) begin
            neuron_rst <= 1'b0;
            state      <= S_LOAD_BIAS;
          end else begin
            nrst_cnt <= 1'b1;
          end
        end
        S_LOAD_BIAS: begin
          if (cfg_fire) begin
            bias_value <= cfg_data;
            bias_valid <= OH0 << n;
            state      <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (cfg_fire) begin
            weight_value      <= cfg_data;
            weight_valid      <= 1'b1;
            config_neuron_num <= NUM_W'(n);
            if (k_last) begin
              state <= n_tc ? S_READY : S_LOAD_BIAS;
            end
          end
        end
        S_READY: begin
          if (cfg_start) begin
            state       <= S_NRST;
            neuron_rst  <= 1'b1;
            nrst_cnt    <= 1'b0;
            err_timeout <= 1'b0;
          end else if (in_fire) begin
            neuron_in       <= in_data;
            neuron_in_valid <= 1'b1;
            seen            <= '0;
            state <= j_last ? S_WAIT_OUT : S_STREAM;
          end
        end
        S_STREAM: begin
          if (in_fire) begin
            neuron_in       <= in_data;
            neuron_in_valid <= 1'b1;
            if (j_last) begin
              state <= S_WAIT_OUT;
            end
          end
        end
        S_WAIT_OUT: begin
          seen <= seen | neuron_outvalid;
          if (all_seen) begin
            state    <= S_DONE;
            vec_done <= 1'b1;
          end else if (t_tc) begin
            err_timeout <= 1'b1;
            seen        <= '0;
            state       <= S_READY;
          end
        end
        S_DONE: begin
          seen  <= '0;
          state <= S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elm_layer_sequencer.sv
// tb_elm_layer_sequencer: directed vectors, scoreboard
// queues and a small behavioural neuron array model.
module tb_elm_layer_sequencer;

  localparam int DW = 16;
  localparam int NN = 4;
  localparam int NW = 8;
  localparam int LN = 1;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_start = 1'b0;
  logic cfg_valid = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic [DW-1:0] in_data = '0;
  logic cfg_ready, in_ready, neuron_rst;
  logic weight_valid, neuron_in_valid;
  logic ready, vec_done, err_timeout;
  logic [DW-1:0] weight_value, bias_value, neuron_in;
  logic [NN-1:0] bias_valid;
  logic [NN-1:0] neuron_outvalid = '0;
  logic [2*DW:0] config_layer_num, config_neuron_num;

  elm_layer_sequencer #(
    .DATA_W(DW), .NUM_NEURONS(NN), .NUM_WEIGHT(NW),
    .LAYER_NO(LN), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .neuron_rst(neuron_rst),
    .weight_value(weight_value),
    .weight_valid(weight_valid),
    .bias_value(bias_value), .bias_valid(bias_valid),
    .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num),
    .neuron_in(neuron_in),
    .neuron_in_valid(neuron_in_valid),
    .neuron_outvalid(neuron_outvalid),
    .ready(ready), .vec_done(vec_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  logic [NN-1:0] q_bo[$];
  logic [DW-1:0] q_bv[$];
  int            q_wn[$];
  logic [DW-1:0] q_wv[$];
  logic [DW-1:0] q_s[$];
  int            q_done[$];
  int nb = 0;
  int nw = 0;

  // scoreboard monitor
  always @(negedge clk) begin
    if (|bias_valid === 1'b1) begin
      nb++;
      chk("bias_expected", q_bo.size() != 0, 1);
      if (q_bo.size() != 0) begin
        chk("bias_onehot", bias_valid, q_bo.pop_front());
        chk("bias_value", bias_value, q_bv.pop_front());
      end
    end
    if (weight_valid === 1'b1) begin
      nw++;
      chk("weight_expected", q_wn.size() != 0, 1);
      if (q_wn.size() != 0) begin
        chk("weight_neuron", config_neuron_num,
            64'(q_wn.pop_front()));
        chk("weight_value", weight_value,
            q_wv.pop_front());
      end
    end
    if (neuron_in_valid === 1'b1) begin
      chk("sample_expected", q_s.size() != 0, 1);
      if (q_s.size() != 0)
        chk("sample_value", neuron_in, q_s.pop_front());
    end
    if (vec_done === 1'b1) begin
      chk("done_expected", q_done.size() != 0, 1);
      if (q_done.size() != 0)
        chk("done_cycle", 64'(cyc),
            64'(q_done.pop_front()));
    end
  end

  // neuron array: outvalid pulses ndly cycles after
  // the falling edge of neuron_in_valid
  int ndly[NN] = '{5, 5, 5, 5};
  bit nen[NN] = '{1, 1, 1, 1};
  int ncnt[NN] = '{0, 0, 0, 0};
  bit prev_niv = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < NN; i++) begin
      neuron_outvalid[i] = 1'b0;
      if (prev_niv && neuron_in_valid !== 1'b1 &&
          nen[i]) begin
        ncnt[i] = ndly[i];
      end else if (ncnt[i] > 0) begin
        ncnt[i]--;
        if (ncnt[i] == 0) neuron_outvalid[i] = 1'b1;
      end
    end
    prev_niv = (neuron_in_valid === 1'b1);
  end

  function automatic logic [DW-1:0] bval(int i);
    return DW'(32'hB000 + i * 17);
  endfunction

  function automatic logic [DW-1:0] wval(int i, int w);
    return DW'(32'hA000 + i * 16 + w);
  endfunction

  task automatic send_cfg(input logic [DW-1:0] d,
                          input bit gap);
    int t = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    while (!cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("cfg_ready_wait", t, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic load_layer(input bit gap,
                            input int stop_k);
    for (int i = 0; i < NN; i++) begin
      q_bo.push_back(NN'(1 << i));
      q_bv.push_back(bval(i));
      send_cfg(bval(i), gap);
      for (int w = 0; w < NW; w++) begin
        if (i == 0 && w == stop_k) return;
        q_wn.push_back(i);
        q_wv.push_back(wval(i, w));
        send_cfg(wval(i, w), gap);
      end
    end
  endtask

  task automatic send_vec(input int base,
                          output int c0);
    for (int s = 0; s < NW; s++) begin
      int t = 0;
      q_s.push_back(DW'(base + s));
      in_data  = DW'(base + s);
      in_valid = 1'b1;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("in_ready_wait", t, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    c0 = cyc;
    chk("in_ready_low_after_last", in_ready, 0);
  endtask

  task automatic start_cfg();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic full_load(input bit gap);
    nb = 0;
    nw = 0;
    load_layer(gap, -1);
    @(negedge clk);
    chk("ready_after_load", ready, 1);
    chk("bias_pulses", nb, NN);
    chk("weight_pulses", nw, NN * NW);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int c0;
    int t;
    repeat (3) @(negedge clk);
    chk("rst_neuron_rst", neuron_rst, 1);
    chk("rst_layer_num", config_layer_num, LN);
    chk("rst_neuron_num", config_neuron_num, 0);
    chk("rst_bias_valid", bias_valid, 0);
    chk("rst_weight_valid", weight_valid, 0);
    chk("rst_in_valid", neuron_in_valid, 0);
    chk("rst_ready", ready, 0);
    chk("rst_vec_done", vec_done, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b1;
    cfg_valid = 1'b1;
    @(negedge clk);
    chk("idle_no_cfg_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    @(negedge clk);

    // back-to-back config load
    start_cfg();
    chk("nrst_cycle1", neuron_rst, 1);
    @(negedge clk);
    chk("nrst_cycle2", neuron_rst, 1);
    @(negedge clk);
    chk("nrst_released", neuron_rst, 0);
    full_load(1'b0);

    // nominal vector
    send_vec(16'h0100, c0);
    q_done.push_back(c0 + 7);
    repeat (12) @(negedge clk);
    chk("vec1_done_seen", q_done.size(), 0);
    chk("vec1_ready", ready, 1);

    // neuron 2 three cycles late, then a normal vector
    ndly[2] = 8;
    send_vec(16'h0200, c0);
    q_done.push_back(c0 + 10);
    repeat (14) @(negedge clk);
    chk("stagger_done_seen", q_done.size(), 0);
    ndly[2] = 5;
    send_vec(16'h0300, c0);
    q_done.push_back(c0 + 7);
    repeat (12) @(negedge clk);
    chk("vec3_done_seen", q_done.size(), 0);

    // neuron 3 silent: timeout
    nen[3] = 1'b0;
    send_vec(16'h0400, c0);
    t = 0;
    while (err_timeout !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("tmo_cycle", 64'(cyc), 64'(c0 + TO));
    chk("tmo_ready", ready, 1);
    repeat (8) @(negedge clk);
    chk("tmo_sticky", err_timeout, 1);
    nen[3] = 1'b1;

    // reload with cfg_valid every other cycle
    start_cfg();
    chk("tmo_cleared", err_timeout, 0);
    chk("reload_nrst", neuron_rst, 1);
    full_load(1'b1);
    send_vec(16'h0500, c0);
    q_done.push_back(c0 + 7);
    repeat (12) @(negedge clk);
    chk("vec5_done_seen", q_done.size(), 0);

    // reset in LOAD_W at k=5
    start_cfg();
    load_layer(1'b0, 5);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_weight_valid", weight_valid, 0);
    chk("mid_rst_bias_valid", bias_valid, 0);
    chk("mid_rst_in_valid", neuron_in_valid, 0);
    chk("mid_rst_vec_done", vec_done, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_neuron_rst", neuron_rst, 1);
    rst = 1'b1;
    @(negedge clk);
    start_cfg();
    full_load(1'b0);
    send_vec(16'h0600, c0);
    q_done.push_back(c0 + 7);
    repeat (12) @(negedge clk);
    chk("vec6_done_seen", q_done.size(), 0);

    chk("bias_q_empty", q_bo.size(), 0);
    chk("weight_q_empty", q_wn.size(), 0);
    chk("sample_q_empty", q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
